// File: rtl/mvu_arb_pkg.sv
// Shared state encoding, tag type and round-robin pick helper for mvu_stream_arbiter.
// tag_t is sized for up to ARB_MAX_REQ requesters so one package serves every N_REQ.
package mvu_arb_pkg;

    localparam int unsigned ARB_MAX_REQ = 16;
    localparam int unsigned TAG_W       = $clog2(ARB_MAX_REQ);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [TAG_W-1:0] tag_t;

    // First valid index at or after ptr, wrapping modulo n_req.
    function automatic tag_t rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                     input tag_t                   ptr,
                                     input int unsigned            n_req);
        tag_t pick;
        tag_t idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
            idx = tag_t'((32'(ptr) + i) % n_req);
            if (!found && (i < n_req) && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mvu_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each vector in flight through the MVU.
// A full FIFO still accepts a push in a cycle where it also pops.
module mvu_arb_tag_fifo
    import mvu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  tag_t i_push_tag,
    input  logic i_pop,
    output tag_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    tag_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; entries are meaningless until written, so left unreset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

endmodule

// File: rtl/mvu_stream_arbiter.sv
// Round-robin, vector-granular arbiter sharing one MVU stream among N_REQ requesters.
// Optional sticky protocol checker on err: define MVU_ARB_PROTOCOL_CHECK_EN.
module mvu_stream_arbiter
    import mvu_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned SF        = 1,
    parameter int unsigned NF        = 1,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ*IN_W-1:0] s_axis_input_tdata,
    input  logic [N_REQ-1:0]      s_axis_input_tvalid,
    output logic [N_REQ-1:0]      s_axis_input_tready,
    output logic [IN_W-1:0]       m_axis_mvu_tdata,
    output logic                  m_axis_mvu_tvalid,
    input  logic                  m_axis_mvu_tready,
    input  logic [OUT_W-1:0]      s_axis_mvu_tdata,
    input  logic                  s_axis_mvu_tvalid,
    output logic                  s_axis_mvu_tready,
    output logic [OUT_W-1:0]      m_axis_output_tdata,
    output logic [N_REQ-1:0]      m_axis_output_tvalid,
    input  logic [N_REQ-1:0]      m_axis_output_tready,
    output logic                  err
);

    localparam int unsigned       REQ_W     = $clog2(N_REQ);
    localparam int unsigned       BEAT_W    = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned       OUT_CW    = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [REQ_W-1:0]  REQ_LAST  = REQ_W'(N_REQ - 1);
    localparam logic [REQ_W-1:0]  REQ_ONE   = REQ_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SF - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [OUT_CW-1:0] OUT_LAST  = OUT_CW'(NF - 1);
    localparam logic [OUT_CW-1:0] OUT_ONE   = OUT_CW'(1);

    state_t            r_state;
    logic [REQ_W-1:0]  r_grant_idx;
    logic [REQ_W-1:0]  r_rr_ptr;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [OUT_CW-1:0] r_out_cnt;

    logic [IN_W-1:0]   w_in_data [N_REQ];
    logic [REQ_W-1:0]  w_pick;
    logic [REQ_W-1:0]  w_head;
    tag_t              w_head_tag;
    logic              w_full;
    logic              w_empty;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_push;
    logic              w_pop;

    for (genvar g = 0; g < N_REQ; g++) begin : g_in_data
        assign w_in_data[g] = s_axis_input_tdata[g*IN_W +: IN_W];
    end

    assign w_pick = REQ_W'(rr_pick(ARB_MAX_REQ'(s_axis_input_tvalid), tag_t'(r_rr_ptr), N_REQ));
    assign w_head = REQ_W'(w_head_tag);

    assign m_axis_mvu_tdata    = w_in_data[r_grant_idx];
    assign m_axis_output_tdata = s_axis_mvu_tdata;

    // Connect only the granted requester to the MVU input while streaming.
    always_comb begin
        s_axis_input_tready = '0;
        m_axis_mvu_tvalid   = 1'b0;
        if (r_state == STREAM) begin
            s_axis_input_tready[r_grant_idx] = m_axis_mvu_tready;
            m_axis_mvu_tvalid                = s_axis_input_tvalid[r_grant_idx];
        end else begin
            s_axis_input_tready = '0;
            m_axis_mvu_tvalid   = 1'b0;
        end
    end

    assign w_in_fire = m_axis_mvu_tvalid && m_axis_mvu_tready;
    assign w_push    = (r_state == STREAM) && w_in_fire && (r_beat_cnt == BEAT_LAST);

    // Results go strictly to the head-of-line owner; a stalled owner blocks everyone.
    always_comb begin
        m_axis_output_tvalid = '0;
        s_axis_mvu_tready    = 1'b0;
        if (!w_empty) begin
            m_axis_output_tvalid[w_head] = s_axis_mvu_tvalid;
            s_axis_mvu_tready            = m_axis_output_tready[w_head];
        end else begin
            m_axis_output_tvalid = '0;
            s_axis_mvu_tready    = 1'b0;
        end
    end

    assign w_out_fire = s_axis_mvu_tvalid && s_axis_mvu_tready;
    assign w_pop      = w_out_fire && (r_out_cnt == OUT_LAST);

    // Grant FSM: one requester per whole vector, then advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((|s_axis_input_tvalid) && !w_full) begin
                        r_grant_idx <= w_pick;
                        r_beat_cnt  <= '0;
                        r_state     <= STREAM;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                STREAM: begin
                    if (w_in_fire && (r_beat_cnt == BEAT_LAST)) begin
                        r_beat_cnt <= '0;
                        r_rr_ptr   <= (r_grant_idx == REQ_LAST) ? '0 : r_grant_idx + REQ_ONE;
                        r_state    <= IDLE;
                    end else if (w_in_fire) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_ONE;
                    end else begin
                        r_beat_cnt <= r_beat_cnt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result beat counter; the head tag retires on its last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else if (w_out_fire) begin
            r_out_cnt <= (r_out_cnt == OUT_LAST) ? '0 : r_out_cnt + OUT_ONE;
        end else begin
            r_out_cnt <= r_out_cnt;
        end
    end

    mvu_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_tag (tag_t'(r_grant_idx)),
        .i_pop      (w_pop),
        .o_head     (w_head_tag),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

`ifdef MVU_ARB_PROTOCOL_CHECK_EN
    logic r_err;

    // Sticky flag: result with no owner, or a tag push the FIFO cannot absorb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((s_axis_mvu_tvalid && w_empty) || (w_push && w_full && !w_pop)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mvu_stream_arbiter.sv
// Directed bench for mvu_stream_arbiter: N_REQ=2, SF=4, NF=2, TAG_DEPTH=2.
// Expected err follows MVU_ARB_PROTOCOL_CHECK_EN.
module tb_mvu_stream_arbiter;

    localparam int N_REQ = 2;
    localparam int SF    = 4;
    localparam int NF    = 2;
    localparam int IN_W  = 8;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;

`ifdef MVU_ARB_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [N_REQ*IN_W-1:0] in_tdata;
    logic [N_REQ-1:0]      in_tvalid;
    logic [N_REQ-1:0]      in_tready;
    logic [IN_W-1:0]       mvu_m_tdata;
    logic                  mvu_m_tvalid;
    logic                  mvu_m_tready;
    logic [OUT_W-1:0]      mvu_s_tdata;
    logic                  mvu_s_tvalid;
    logic                  mvu_s_tready;
    logic [OUT_W-1:0]      out_tdata;
    logic [N_REQ-1:0]      out_tvalid;
    logic [N_REQ-1:0]      out_tready;
    logic                  err;

    int vecs = 0;
    int miss = 0;

    mvu_stream_arbiter #(
        .N_REQ(N_REQ), .SF(SF), .NF(NF), .IN_W(IN_W), .OUT_W(OUT_W), .TAG_DEPTH(DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_input_tdata   (in_tdata),
        .s_axis_input_tvalid  (in_tvalid),
        .s_axis_input_tready  (in_tready),
        .m_axis_mvu_tdata     (mvu_m_tdata),
        .m_axis_mvu_tvalid    (mvu_m_tvalid),
        .m_axis_mvu_tready    (mvu_m_tready),
        .s_axis_mvu_tdata     (mvu_s_tdata),
        .s_axis_mvu_tvalid    (mvu_s_tvalid),
        .s_axis_mvu_tready    (mvu_s_tready),
        .m_axis_output_tdata  (out_tdata),
        .m_axis_output_tvalid (out_tvalid),
        .m_axis_output_tready (out_tready),
        .err                  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_tvalid    = 2'b00;
        mvu_m_tready = 1'b0;
        mvu_s_tvalid = 1'b0;
        mvu_s_tdata  = 32'h0;
        out_tready   = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] onehot(input int g);
        return 2'b01 << g;
    endfunction

    initial begin
        logic stream;
        logic drive;
        int   g;

        rst          = 1'b1;
        in_tdata     = 16'h0;
        in_tvalid    = 2'b00;
        mvu_m_tready = 1'b0;
        mvu_s_tvalid = 1'b0;
        mvu_s_tdata  = 32'h0;
        out_tready   = 2'b00;
        #1;
        chk("rst_in_tready", 32'(in_tready), 32'h0);
        chk("rst_mvu_tvalid", 32'(mvu_m_tvalid), 32'h0);
        chk("rst_mvu_s_tready", 32'(mvu_s_tready), 32'h0);
        chk("rst_out_tvalid", 32'(out_tvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Single requester: grant, four beats, two results on req0 only.
        mvu_m_tready = 1'b1;
        in_tdata     = 16'h00A0;
        in_tvalid    = 2'b01;
        #1;
        chk("t1_idle_tready", 32'(in_tready), 32'h0);
        chk("t1_idle_tvalid", 32'(mvu_m_tvalid), 32'h0);
        for (int b = 0; b < SF; b++) begin
            tick();
            in_tdata[7:0] = 8'hA0 + 8'(b);
            #1;
            chk("t1_beat_tready", 32'(in_tready), 32'h1);
            chk("t1_beat_tvalid", 32'(mvu_m_tvalid), 32'h1);
            chk("t1_beat_tdata", 32'(mvu_m_tdata), 32'hA0 + 32'(b));
        end
        tick();
        in_tvalid = 2'b00;
        #1;
        chk("t1_done_tready", 32'(in_tready), 32'h0);
        mvu_s_tvalid = 1'b1;
        out_tready   = 2'b11;
        for (int r = 0; r < NF; r++) begin
            mvu_s_tdata = 32'hBEEF0000 + 32'(r);
            #1;
            chk("t1_res_tvalid", 32'(out_tvalid), 32'h1);
            chk("t1_res_s_tready", 32'(mvu_s_tready), 32'h1);
            chk("t1_res_tdata", out_tdata, 32'hBEEF0000 + 32'(r));
            tick();
        end
        chk("t1_empty_tvalid", 32'(out_tvalid), 32'h0);
        chk("t1_empty_s_tready", 32'(mvu_s_tready), 32'h0);
        mvu_s_tvalid = 1'b0;

        // Both requesters always valid: grants 0,1,0,1 with one bubble per vector.
        do_reset();
        in_tdata     = 16'hC35A;
        mvu_m_tready = 1'b1;
        out_tready   = 2'b11;
        for (int c = 0; c < 22; c++) begin
            in_tvalid    = (c < 20) ? 2'b11 : 2'b00;
            drive        = (c >= 5) && ((c % 5) < 2);
            mvu_s_tvalid = drive;
            mvu_s_tdata  = 32'h1000 + 32'(c);
            #1;
            stream = ((c % 5) != 0) && (c < 20);
            g      = (c / 5) % 2;
            chk("t2_tready", 32'(in_tready), stream ? 32'(onehot(g)) : 32'h0);
            chk("t2_mvu_tvalid", 32'(mvu_m_tvalid), 32'(stream));
            if (stream) begin
                chk("t2_mvu_tdata", 32'(mvu_m_tdata), (g == 1) ? 32'hC3 : 32'h5A);
            end
            chk("t2_out_tvalid", 32'(out_tvalid), drive ? 32'(onehot(((c / 5) - 1) % 2)) : 32'h0);
            chk("t2_s_tready", 32'(mvu_s_tready), 32'(drive));
            if (drive) begin
                chk("t2_out_tdata", out_tdata, 32'h1000 + 32'(c));
            end
            tick();
        end

        // Tag FIFO full blocks grants until a result vector drains.
        do_reset();
        in_tdata     = 16'h0077;
        mvu_m_tready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            in_tvalid    = 2'b01;
            drive        = (c >= 11) && (c < 15);
            mvu_s_tvalid = drive;
            mvu_s_tdata  = 32'h3000 + 32'(c);
            out_tready   = ((c == 13) || (c == 14)) ? 2'b01 : 2'b00;
            #1;
            stream = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9)) || (c == 16);
            chk("t3_tready", 32'(in_tready), stream ? 32'h1 : 32'h0);
            if (drive) begin
                chk("t3_out_tvalid", 32'(out_tvalid), 32'h1);
                chk("t3_s_tready", 32'(mvu_s_tready), (c >= 13) ? 32'h1 : 32'h0);
            end
            tick();
        end

        // Head owned by req1: req0 readiness must not drain it.
        do_reset();
        in_tdata     = 16'h9900;
        in_tvalid    = 2'b10;
        mvu_m_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_tready", 32'(in_tready), (c >= 1) ? 32'h2 : 32'h0);
            if (c >= 1) begin
                chk("t4_mvu_tdata", 32'(mvu_m_tdata), 32'h99);
            end
            tick();
        end
        in_tvalid    = 2'b00;
        mvu_s_tvalid = 1'b1;
        out_tready   = 2'b01;
        #1;
        chk("t4_hol_s_tready", 32'(mvu_s_tready), 32'h0);
        chk("t4_hol_out_tvalid", 32'(out_tvalid), 32'h2);
        out_tready = 2'b10;
        #1;
        chk("t4_owner_s_tready", 32'(mvu_s_tready), 32'h1);
        chk("t4_err_clean", 32'(err), 32'h0);
        mvu_s_tvalid = 1'b0;

        // Result with no owner; err sticks through traffic until reset.
        do_reset();
        mvu_s_tvalid = 1'b1;
        #1;
        tick();
        mvu_s_tvalid = 1'b0;
        #1;
        chk("t6_err_set", 32'(err), 32'(EXP_ERR));
        in_tdata     = 16'h0011;
        in_tvalid    = 2'b01;
        mvu_m_tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
        end
        in_tvalid = 2'b00;
        #1;
        chk("t6_err_hold", 32'(err), 32'(EXP_ERR));
        rst = 1'b1;
        #1;
        chk("t6_err_rst", 32'(err), 32'h0);

        // Reset after two beats of a vector: async clear, then fresh round-robin state.
        do_reset();
        in_tdata     = 16'h2211;
        mvu_m_tready = 1'b1;
        in_tvalid    = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        in_tvalid = 2'b11;
        tick();
        #1;
        chk("t5_grant1", 32'(in_tready), 32'h2);
        tick();
        tick();
        #1;
        chk("t5_mid_tready", 32'(in_tready), 32'h2);
        mvu_s_tvalid = 1'b1;
        out_tready   = 2'b11;
        #1;
        chk("t5_pre_out_tvalid", 32'(out_tvalid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_async_tready", 32'(in_tready), 32'h0);
        chk("t5_async_mvu_tvalid", 32'(mvu_m_tvalid), 32'h0);
        chk("t5_async_s_tready", 32'(mvu_s_tready), 32'h0);
        chk("t5_async_out_tvalid", 32'(out_tvalid), 32'h0);
        mvu_s_tvalid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_idle_tready", 32'(in_tready), 32'h0);
        chk("t5_fifo_empty", 32'(mvu_s_tready), 32'h0);
        tick();
        chk("t5_rr_ptr_zero", 32'(in_tready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
